// File: rtl/bit_shift_sequencer.sv
// rtl/bit_shift_sequencer.sv - steps a latched pattern through shift positions 0..3 with a dwell per step
module bit_shift_sequencer #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [4:0] pattern_in,
  input  logic [7:0] shifted_data,
  output logic [4:0] num_of_ones,
  output logic [1:0] shift_by_n_pos,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_DWELL  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       ones_q, ones_d;
  logic [1:0]       pos_q, pos_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loop_q, loop_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    pos_d   = pos_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          ones_d  = pattern_in;
          loop_d  = loop_en;
          pos_d   = 2'd0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // A stop arriving on the sample edge also cancels the capture.
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          data_d  = shifted_data;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == DWELL_LAST) begin
          if (pos_q != 2'd3 || loop_q) begin
            pos_d   = pos_q + 2'd1;
            state_d = S_SAMPLE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SAMPLE) || (state_d == S_DWELL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      pos_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      loop_q  <= loop_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign num_of_ones    = ones_q;
  assign shift_by_n_pos = pos_q;
  assign data_out       = data_q;
  assign data_valid     = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_bit_shift_sequencer.sv
// tb/tb_bit_shift_sequencer.sv - bench for bit_shift_sequencer with a stubbed shifter and DWELL_CYCLES=4
module tb_bit_shift_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [4:0] pattern_in = '0;
  logic [7:0] shifted_data;
  logic [4:0] num_of_ones;
  logic [1:0] shift_by_n_pos;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       done;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int pulse_cyc[$];
  logic [7:0] pulse_dat[$];
  int done_cyc[$];

  typedef struct {
    logic [4:0]  pat;
    logic [31:0] exp;
  } vec_t;

  bit_shift_sequencer #(.DWELL_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .pattern_in(pattern_in), .shifted_data(shifted_data),
    .num_of_ones(num_of_ones), .shift_by_n_pos(shift_by_n_pos),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  assign shifted_data = {1'b1, shift_by_n_pos, num_of_ones};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(data_out);
    end
    if (done) done_cyc.push_back(cyc);
  end

  function automatic logic [7:0] model_data(input logic [4:0] pat, input int step);
    logic [1:0] pos;
    pos = 2'(step % 4);
    return {1'b1, pos, pat};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pulse_dat.delete();
    done_cyc.delete();
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget && pulse_dat.size() < n; i++) @(posedge clk);
    if (pulse_dat.size() < n) chk({name, "_timeout"}, pulse_dat.size(), n);
  endtask

  task automatic run_oneshot(input logic [4:0] pat, input logic [31:0] exp, input string name);
    int s;
    int i;
    clear_mon();
    @(posedge clk); #1;
    s = cyc;
    pattern_in = pat; loop_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pattern_in = 5'($urandom); loop_en = 1'($urandom);
    for (i = 0; i < 40 && done_cyc.size() == 0; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk({name, "_pulses"}, pulse_dat.size(), 4);
    chk({name, "_done_cnt"}, done_cyc.size(), 1);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_ones_kept"}, num_of_ones, pat);
    if (pulse_dat.size() == 4) begin
      for (int k = 0; k < 4; k++) chk({name, "_data"}, pulse_dat[k], exp[31-8*k -: 8]);
      chk({name, "_first_lat"}, pulse_cyc[0] - s, 2);
      chk({name, "_period"}, pulse_cyc[3] - pulse_cyc[0], 3 * (D + 1));
      if (done_cyc.size() == 1) chk({name, "_done_lat"}, done_cyc[0] - pulse_cyc[0], 4 * (D + 1));
    end
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{5'b11011, 32'h9BBBDBFB};
    vecs[1] = '{5'b00001, 32'h81A1C1E1};
    vecs[2] = '{5'b10100, 32'h94B4D4F4};

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); stop = 1'($urandom); loop_en = 1'($urandom); pattern_in = 5'($urandom);
      @(negedge clk);
      chk("reset_outputs", {num_of_ones, shift_by_n_pos, data_out, data_valid, busy, done}, 0);
    end
    start = 0; stop = 0; loop_en = 0;
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 3; i++) run_oneshot(vecs[i].pat, vecs[i].exp, "table");

    for (int i = 0; i < 5; i++) begin
      logic [4:0]  p;
      logic [31:0] e;
      p = 5'($urandom);
      e = {model_data(p, 0), model_data(p, 1), model_data(p, 2), model_data(p, 3)};
      run_oneshot(p, e, "rand");
    end

    // looping run, restart attempts and pattern change mid-run, stop mid-dwell at pos 2
    clear_mon();
    @(posedge clk); #1;
    pattern_in = 5'b00001; loop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 0;
    wait_pulses(1, 20, "loop_first");
    #1 start = 1; pattern_in = 5'b11111; loop_en = 0;
    repeat (3) @(posedge clk);
    #1 start = 0;
    wait_pulses(7, 60, "loop_seven");
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    @(negedge clk);
    chk("loop_busy_after_stop", busy, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("loop_pulses", pulse_dat.size(), 7);
    chk("loop_no_done", done_cyc.size(), 0);
    chk("loop_data_kept", data_out, 8'hC1);
    if (pulse_dat.size() == 7)
      for (int k = 0; k < 7; k++) chk("loop_data", pulse_dat[k], model_data(5'b00001, k));

    // stop coincident with dwell expiry at pos 3 (one-shot)
    clear_mon();
    @(posedge clk); #1;
    pattern_in = 5'b11011; loop_en = 0; start = 1;
    @(posedge clk); #1 start = 0;
    wait_pulses(4, 40, "expiry");
    repeat (2) @(posedge clk);
    #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("expiry_pulses", pulse_dat.size(), 4);
    chk("expiry_no_done", done_cyc.size(), 0);
    chk("expiry_busy", busy, 0);
    chk("expiry_data_kept", data_out, 8'hFB);

    // stop on the sample edge suppresses the capture
    clear_mon();
    @(posedge clk); #1;
    pattern_in = 5'b00111; start = 1;
    @(posedge clk); #1 start = 0; stop = 1;
    @(posedge clk); #1 stop = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("sample_stop_pulses", pulse_dat.size(), 0);
    chk("sample_stop_data", data_out, 8'hFB);
    chk("sample_stop_ones", num_of_ones, 5'b00111);
    chk("sample_stop_busy", busy, 0);

    // start with stop in IDLE is not accepted
    @(posedge clk); #1;
    pattern_in = 5'b10101; start = 1; stop = 1;
    @(posedge clk); #1 start = 0; stop = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("start_stop_busy", busy, 0);
    chk("start_stop_pulses", pulse_dat.size(), 0);
    chk("start_stop_ones", num_of_ones, 5'b00111);

    // asynchronous reset mid-dwell
    clear_mon();
    @(posedge clk); #1;
    pattern_in = 5'b11011; start = 1;
    @(posedge clk); #1 start = 0;
    wait_pulses(1, 20, "rst_first");
    @(posedge clk); #1 rst = 1;
    #1;
    chk("rst_async_outputs", {num_of_ones, shift_by_n_pos, data_out, data_valid, busy, done}, 0);
    @(posedge clk); #1 rst = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_done", done_cyc.size(), 0);
    chk("rst_pulses", pulse_dat.size(), 1);
    chk("rst_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
